// File: rtl/dp_mem_pkg.sv
// Shared widths, channel state encoding and command payload for the dual-port memory initiator.
package dp_mem_pkg;

  localparam int unsigned ADDR_W                 = 32;
  localparam int unsigned DATA_W                 = 32;
  localparam int unsigned MASK_W                 = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } port_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_cmd_t;

  // Width of a counter that must be able to hold the value 'cycles'.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/dp_mem_port_fsm.sv
// One memory channel: accept a request, hold the command until the responder answers
// or the BUSY timer expires, then spend one DRAIN cycle before accepting again.
module dp_mem_port_fsm
  import dp_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [MASK_W-1:0] i_req_wmask,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_err,
  output logic              o_read,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [MASK_W-1:0] o_wmask,
  input  logic              i_resp,
  input  logic [DATA_W-1:0] i_rdata
);

  localparam int unsigned      CNT_W    = timer_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  port_state_e       r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  mem_cmd_t          r_cmd,       w_cmd_nxt;
  logic              r_read,      w_read_nxt;
  logic              r_write,     w_write_nxt;
  logic              r_ready,     w_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data,  w_rsp_data_nxt;
  logic              r_err,       w_err_nxt;
  logic              w_first_busy;
  logic              w_timeout;

  // A zero count marks the first BUSY cycle, where a lingering resp from the previous command is masked.
  assign w_first_busy = (r_cnt == '0);
  assign w_timeout    = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cmd_nxt       = r_cmd;
    w_read_nxt      = r_read;
    w_write_nxt     = r_write;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_err_nxt       = r_err;

    case (r_state)
      ST_IDLE: begin
        if (i_req_valid && r_ready) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = '0;
          w_cmd_nxt   = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata, wmask: i_req_wmask};
          w_read_nxt  = !i_req_we;
          w_write_nxt = i_req_we;
        end
      end
      ST_BUSY: begin
        if (i_resp && !w_first_busy) begin
          w_state_nxt     = ST_DRAIN;
          w_read_nxt      = 1'b0;
          w_write_nxt     = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          if (!r_cmd.we) begin
            w_rsp_data_nxt = i_rdata;
          end
        end else if (w_timeout) begin
          w_state_nxt     = ST_DRAIN;
          w_read_nxt      = 1'b0;
          w_write_nxt     = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_err_nxt       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd       <= w_cmd_nxt;
      r_read      <= w_read_nxt;
      r_write     <= w_write_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_req_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_err       = r_err;
  assign o_read      = r_read;
  assign o_write     = r_write;
  assign o_addr      = r_cmd.addr;
  assign o_wdata     = r_cmd.wdata;
  assign o_wmask     = r_cmd.wmask;

endmodule

// File: rtl/dp_mem_initiator.sv
// Dual-port memory initiator: read-only fetch channel on port A, read/write data channel on port B.
module dp_mem_initiator
  import dp_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [MASK_W-1:0] d_req_wmask,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_err,
  output logic              read_a,
  output logic [ADDR_W-1:0] address_a,
  input  logic              resp_a,
  input  logic [DATA_W-1:0] rdata_a,
  output logic              read_b,
  output logic              write,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] wdata,
  output logic [MASK_W-1:0] wmask,
  input  logic              resp_b,
  input  logic [DATA_W-1:0] rdata_b
);

  // Port A never writes, so its write-side outputs exist only to be discarded.
  logic              w_a_write;
  logic [DATA_W-1:0] w_a_wdata;
  logic [MASK_W-1:0] w_a_wmask;
  logic              w_a_unused;

  assign w_a_unused = ^{w_a_write, w_a_wdata, w_a_wmask};

  dp_mem_port_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_port_a (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (f_req_valid),
    .i_req_we    (1'b0),
    .i_req_addr  (f_req_addr),
    .i_req_wdata ('0),
    .i_req_wmask ('0),
    .o_req_ready (f_req_ready),
    .o_rsp_valid (f_rsp_valid),
    .o_rsp_data  (f_rsp_data),
    .o_err       (f_err),
    .o_read      (read_a),
    .o_write     (w_a_write),
    .o_addr      (address_a),
    .o_wdata     (w_a_wdata),
    .o_wmask     (w_a_wmask),
    .i_resp      (resp_a),
    .i_rdata     (rdata_a)
  );

  dp_mem_port_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_port_b (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (d_req_valid),
    .i_req_we    (d_req_we),
    .i_req_addr  (d_req_addr),
    .i_req_wdata (d_req_wdata),
    .i_req_wmask (d_req_wmask),
    .o_req_ready (d_req_ready),
    .o_rsp_valid (d_rsp_valid),
    .o_rsp_data  (d_rsp_rdata),
    .o_err       (d_err),
    .o_read      (read_b),
    .o_write     (write),
    .o_addr      (address_b),
    .o_wdata     (wdata),
    .o_wmask     (wmask),
    .i_resp      (resp_b),
    .i_rdata     (rdata_b)
  );

endmodule
